// File: rtl/io_ccff_loader.sv
// io_ccff_loader
// Loads the I/O tile configuration chain from a host word stream. Each word
// is serialised LSB first onto ccff_head, one ccff_en pulse per bit. An
// optional verify pass loops ccff_tail back into ccff_head for CHAIN_LEN
// shifts. This leaves the chain contents unchanged. The pass also compares a
// CRC-8 of the written bits with a CRC-8 of the bits read back.
//
// Ports
//   prog_clk    configuration clock (block and chain)
//   prog_rst_n  synchronous active-low reset
//   start       one-cycle load request, honoured in IDLE only
//   verify_en   sampled with start; 1 adds the verify pass
//   in_valid    host word valid
//   in_ready    block can accept a word
//   in_data     bitstream word, shifted LSB first
//   ccff_head   serial bit to the chain
//   ccff_en     chain shift enable (gates prog_clk to the chain)
//   ccff_tail   chain output, last flop
//   busy        high in LOAD and VERIFY
//   done        one-cycle completion pulse
//   pass        verify result, held until the next start
module io_ccff_loader #(
  parameter int CHAIN_LEN = 6,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              verify_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
  localparam int BUF_CNT_W = $clog2(WORD_W + 1);
  localparam int WCNT_W    = $clog2(N_WORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t               state, state_d;
  logic                 verify_q;
  logic [WORD_W-1:0]    shift_q;
  logic [BUF_CNT_W-1:0] buf_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WCNT_W-1:0]    word_cnt;
  logic [7:0]           crc_wr, crc_rd, crc_rd_d;
  logic                 pass_q;

  logic                 buf_empty;
  logic                 last_bit;
  logic                 accept;
  logic [BUF_CNT_W-1:0] load_cnt;
  int                   remaining;

  // Serial CRC-8, polynomial x^8+x^2+x+1 (0x07).
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign buf_empty = (buf_cnt == '0);
  assign last_bit  = (bit_cnt == BIT_W'(CHAIN_LEN - 1));
  assign in_ready  = (state == S_LOAD) && buf_empty && (word_cnt < WCNT_W'(N_WORDS));
  assign accept    = in_valid && in_ready;
  assign ccff_en   = ((state == S_LOAD) && !buf_empty) || (state == S_VERIFY);
  assign busy      = (state == S_LOAD) || (state == S_VERIFY);
  assign done      = (state == S_DONE);
  assign pass      = pass_q;
  assign crc_rd_d  = crc8_step(crc_rd, ccff_tail);

  // The buffer is empty whenever a word is accepted. All bits taken so far have
  // already been shifted out. The bits still to load are CHAIN_LEN - bit_cnt.
  // Only that many bits of the last word are shifted out. Its upper bits are
  // never driven.
  always_comb begin
    remaining = CHAIN_LEN - int'(bit_cnt);
    load_cnt  = (remaining < WORD_W) ? BUF_CNT_W'(remaining) : BUF_CNT_W'(WORD_W);
  end

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    ccff_head = 1'b0;
    case (state)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD: begin
        ccff_head = shift_q[0] & !buf_empty;
        if (ccff_en && last_bit) state_d = verify_q ? S_VERIFY : S_DONE;
      end
      S_VERIFY: begin
        // Loopback keeps the chain contents intact across the read-back.
        ccff_head = ccff_tail;
        if (last_bit) state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, whatever order the statements
  // appear in.
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      state    <= S_IDLE;
      verify_q <= 1'b0;
      shift_q  <= '0;
      buf_cnt  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      crc_wr   <= 8'h00;
      crc_rd   <= 8'h00;
      pass_q   <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (start) begin
            verify_q <= verify_en;
            buf_cnt  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            crc_wr   <= 8'h00;
            crc_rd   <= 8'h00;
            pass_q   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            shift_q  <= in_data;
            buf_cnt  <= load_cnt;
            word_cnt <= word_cnt + 1'b1;
          end else if (!buf_empty) begin
            shift_q <= shift_q >> 1;
            buf_cnt <= buf_cnt - 1'b1;
            crc_wr  <= crc8_step(crc_wr, shift_q[0]);
            // bit_cnt is reused as the VERIFY shift counter, so it restarts
            // from zero once the last bit has been written.
            if (last_bit) begin
              bit_cnt <= '0;
              if (!verify_q) pass_q <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_VERIFY: begin
          crc_rd <= crc_rd_d;
          if (last_bit) begin
            bit_cnt <= '0;
            // The comparison includes the final sampled tail bit.
            pass_q  <= (crc_rd_d == crc_wr);
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_ccff_loader.sv
// Bench for io_ccff_loader. It drives two instances: a 6-flop chain and a
// 20-flop chain, both with 8-bit words. Each instance has a behavioural chain
// model. Negedge monitors log the shifted bits, handshakes and completion.
module tb_io_ccff_loader;

  logic prog_clk = 1'b0;
  logic prog_rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) cyc++;

  // ---------------- instance A: CHAIN_LEN 6 ----------------
  logic       a_start = 0, a_ver = 0, a_valid = 0;
  logic [7:0] a_data = '0;
  logic       a_ready, a_head, a_en, a_tail, a_busy, a_done, a_pass;
  logic [5:0] a_chain = '0, a_nxt;
  logic       a_stuck3 = 0;

  io_ccff_loader #(.CHAIN_LEN(6), .WORD_W(8)) dut_a (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(a_start), .verify_en(a_ver),
    .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data), .ccff_head(a_head),
    .ccff_en(a_en), .ccff_tail(a_tail), .busy(a_busy), .done(a_done), .pass(a_pass));

  // chain[0] is the first flop; ccff_tail is the last one.
  always @(posedge prog_clk) begin
    if (a_en) begin
      a_nxt = {a_chain[4:0], a_head};
      if (a_stuck3) a_nxt[3] = 1'b0;
      a_chain <= a_nxt;
    end
  end
  assign a_tail = a_chain[5];

  logic a_heads[$], a_tails[$];
  int   a_xfers = 0, a_done_cnt = 0, a_done_cyc = -1, a_start_cyc = 0;
  logic a_pass_done = 0;

  always @(negedge prog_clk) begin
    if (a_en) begin
      a_heads.push_back(a_head);
      a_tails.push_back(a_tail);
    end
    if (a_valid && a_ready) a_xfers++;
    if (a_done) begin
      a_done_cnt++;
      a_done_cyc  = cyc - a_start_cyc;
      a_pass_done = a_pass;
    end
  end

  // ---------------- instance B: CHAIN_LEN 20 ----------------
  logic        b_start = 0, b_ver = 0, b_valid = 0;
  logic [7:0]  b_data = '0;
  logic        b_ready, b_head, b_en, b_tail, b_busy, b_done, b_pass;
  logic [19:0] b_chain = '0;

  io_ccff_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(b_start), .verify_en(b_ver),
    .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data), .ccff_head(b_head),
    .ccff_en(b_en), .ccff_tail(b_tail), .busy(b_busy), .done(b_done), .pass(b_pass));

  always @(posedge prog_clk) if (b_en) b_chain <= {b_chain[18:0], b_head};
  assign b_tail = b_chain[19];

  logic b_heads[$], b_tails[$];
  int   b_xfers = 0, b_done_cnt = 0, b_done_cyc = -1, b_start_cyc = 0;
  int   b_rises = 0, b_late_ready = 0, b_en_ready = 0, b_gap_cycles = 0;
  logic b_pass_done = 0, b_ready_prev = 0;

  always @(negedge prog_clk) begin
    if (b_en) begin
      b_heads.push_back(b_head);
      b_tails.push_back(b_tail);
    end
    if (b_ready && !b_ready_prev) b_rises++;
    if (b_ready && b_xfers >= 3) b_late_ready++;
    if (b_ready && b_en) b_en_ready++;
    if (b_ready && !b_valid) b_gap_cycles++;
    b_ready_prev = b_ready;
    if (b_valid && b_ready) b_xfers++;
    if (b_done) begin
      b_done_cnt++;
      b_done_cyc  = cyc - b_start_cyc;
      b_pass_done = b_pass;
    end
  end

  logic [7:0]  a_word = 8'h2D;
  logic [7:0]  b_words [3] = '{8'hA5, 8'h3C, 8'hFF};
  // Bit k is the k-th bit shifted: A5 then 3C then the low nibble of FF.
  logic [19:0] b_exp = 20'hF3CA5;

  // ---------------- drivers ----------------
  // One load on A with 0x2D held valid. If mid_start >= 1, start is pulsed
  // again in that cycle.
  task automatic run_a(input logic ver, input int mid_start);
    a_heads.delete(); a_tails.delete();
    a_xfers = 0; a_done_cnt = 0; a_done_cyc = -1; a_pass_done = 0;
    @(posedge prog_clk); #1;
    a_start = 1; a_ver = ver; a_valid = 1; a_data = a_word; a_start_cyc = cyc;
    for (int i = 1; i < 40 && a_done_cnt == 0; i++) begin
      @(posedge prog_clk); #1;
      a_start = (i == mid_start);
    end
    a_start = 0; a_valid = 0;
    repeat (2) @(posedge prog_clk);
    #1;
  endtask

  // One verified load on B. If gap > 0, in_valid drops after each accepted
  // word. It stays low for the 8 shift cycles plus gap idle cycles.
  task automatic run_b(input int gap);
    int last, hold;
    b_heads.delete(); b_tails.delete();
    b_xfers = 0; b_done_cnt = 0; b_done_cyc = -1; b_pass_done = 0;
    b_rises = 0; b_late_ready = 0; b_en_ready = 0; b_gap_cycles = 0;
    last = 0; hold = 0;
    @(posedge prog_clk); #1;
    b_start = 1; b_ver = 1; b_valid = 1; b_data = b_words[0]; b_start_cyc = cyc;
    for (int i = 1; i < 200 && b_done_cnt == 0; i++) begin
      @(posedge prog_clk); #1;
      b_start = 0;
      b_data  = b_words[(b_xfers > 2) ? 2 : b_xfers];
      if (gap > 0 && b_xfers != last) begin
        hold = 8 + gap;
        last = b_xfers;
      end
      if (hold > 0) begin
        b_valid = 0;
        hold--;
      end else begin
        b_valid = 1;
      end
    end
    b_valid = 0;
    repeat (2) @(posedge prog_clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk);
    checks++;
    if ({a_ready, a_head, a_en, a_busy, a_done, a_pass} !== 6'b0) begin
      errors++;
      $display("FAIL reset_a ready/head/en/busy/done/pass got %b want 000000",
               {a_ready, a_head, a_en, a_busy, a_done, a_pass});
    end
    checks++;
    if ({b_ready, b_head, b_en, b_busy, b_done, b_pass} !== 6'b0) begin
      errors++;
      $display("FAIL reset_b ready/head/en/busy/done/pass got %b want 000000",
               {b_ready, b_head, b_en, b_busy, b_done, b_pass});
    end
    @(posedge prog_clk); #1;
    prog_rst_n = 1;
  endtask

  task automatic check_a_stream(input string name, input int exp_len, input int exp_done);
    checks++;
    if (a_heads.size() != exp_len) begin
      errors++;
      $display("FAIL %s_en_count got %0d want %0d", name, a_heads.size(), exp_len);
    end
    for (int k = 0; k < 6 && k < a_heads.size(); k++) begin
      checks++;
      if (a_heads[k] !== a_word[k]) begin
        errors++;
        $display("FAIL %s_head_bit%0d got %b want %b", name, k, a_heads[k], a_word[k]);
      end
    end
    checks++;
    if (a_done_cnt != 1 || a_done_cyc != exp_done) begin
      errors++;
      $display("FAIL %s_done pulses %0d at cycle %0d want 1 at cycle %0d",
               name, a_done_cnt, a_done_cyc, exp_done);
    end
    checks++;
    if (a_xfers != 1) begin
      errors++;
      $display("FAIL %s_words got %0d want 1", name, a_xfers);
    end
  endtask

  task automatic test_load_no_verify;
    run_a(1'b0, -1);
    check_a_stream("noverify", 6, 8);
    checks++;
    if (a_pass_done !== 1'b1) begin
      errors++;
      $display("FAIL noverify_pass got %b want 1", a_pass_done);
    end
    checks++;
    if (a_pass !== 1'b1) begin
      errors++;
      $display("FAIL noverify_pass_held got %b want 1", a_pass);
    end
  endtask

  task automatic test_load_verify;
    run_a(1'b1, -1);
    check_a_stream("verify", 12, 14);
    for (int k = 0; k < 6 && k + 6 < a_tails.size(); k++) begin
      checks++;
      if (a_tails[k + 6] !== a_word[k]) begin
        errors++;
        $display("FAIL verify_tail_bit%0d got %b want %b", k, a_tails[k + 6], a_word[k]);
      end
    end
    checks++;
    if (a_pass_done !== 1'b1) begin
      errors++;
      $display("FAIL verify_pass got %b want 1", a_pass_done);
    end
    // The first bit written ends up in the last flop.
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (a_chain[5 - k] !== a_word[k]) begin
        errors++;
        $display("FAIL verify_chain_flop%0d got %b want %b", 5 - k, a_chain[5 - k], a_word[k]);
      end
    end
  endtask

  task automatic test_stuck_flop;
    a_stuck3 = 1;
    run_a(1'b1, -1);
    a_stuck3 = 0;
    checks++;
    if (a_done_cnt != 1 || a_pass_done !== 1'b0) begin
      errors++;
      $display("FAIL stuck_pass done %0d pass %b want done 1 pass 0", a_done_cnt, a_pass_done);
    end
  endtask

  task automatic test_multi_word(input int gap, input int exp_done, input string name);
    run_b(gap);
    checks++;
    if (b_xfers != 3 || b_heads.size() != 40) begin
      errors++;
      $display("FAIL %s_counts words %0d en %0d want 3 and 40", name, b_xfers, b_heads.size());
    end
    for (int k = 0; k < 20 && k < b_heads.size(); k++) begin
      checks++;
      if (b_heads[k] !== b_exp[k]) begin
        errors++;
        $display("FAIL %s_head_bit%0d got %b want %b", name, k, b_heads[k], b_exp[k]);
      end
    end
    for (int k = 0; k < 20 && k + 20 < b_tails.size(); k++) begin
      checks++;
      if (b_tails[k + 20] !== b_exp[k]) begin
        errors++;
        $display("FAIL %s_tail_bit%0d got %b want %b", name, k, b_tails[k + 20], b_exp[k]);
      end
    end
    checks++;
    if (b_rises != 3 || b_late_ready != 0) begin
      errors++;
      $display("FAIL %s_ready rises %0d late %0d want 3 and 0", name, b_rises, b_late_ready);
    end
    checks++;
    if (b_en_ready != 0) begin
      errors++;
      $display("FAIL %s_en_while_ready got %0d want 0", name, b_en_ready);
    end
    checks++;
    if (b_gap_cycles != 2 * gap) begin
      errors++;
      $display("FAIL %s_gap_cycles got %0d want %0d", name, b_gap_cycles, 2 * gap);
    end
    checks++;
    if (b_done_cnt != 1 || b_done_cyc != exp_done || b_pass_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done pulses %0d cycle %0d pass %b want 1 %0d 1",
               name, b_done_cnt, b_done_cyc, b_pass_done, exp_done);
    end
    checks++;
    if (b_chain !== {<<{b_exp}}) begin
      errors++;
      $display("FAIL %s_chain got %h want %h", name, b_chain, {<<{b_exp}});
    end
  endtask

  task automatic test_reset_mid_load;
    a_heads.delete(); a_tails.delete();
    a_done_cnt = 0;
    @(posedge prog_clk); #1;
    a_start = 1; a_ver = 0; a_valid = 1; a_data = a_word; a_start_cyc = cyc;
    @(posedge prog_clk); #1;
    a_start = 0;
    for (int i = 0; i < 20 && a_heads.size() < 3; i++) @(negedge prog_clk);
    checks++;
    if (a_heads.size() != 3) begin
      errors++;
      $display("FAIL rst_mid_reach_3_shifts got %0d want 3", a_heads.size());
    end
    @(posedge prog_clk); #1;
    prog_rst_n = 0;
    @(posedge prog_clk); #1;
    prog_rst_n = 1;
    a_valid = 0;
    @(negedge prog_clk);
    checks++;
    if ({a_en, a_busy, a_done} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_outputs en/busy/done got %b want 000", {a_en, a_busy, a_done});
    end
    repeat (12) @(posedge prog_clk);
    checks++;
    if (a_done_cnt != 0) begin
      errors++;
      $display("FAIL rst_mid_no_done got %0d want 0", a_done_cnt);
    end
    #1;
    run_a(1'b0, -1);
    check_a_stream("after_rst", 6, 8);
    checks++;
    if (a_pass_done !== 1'b1) begin
      errors++;
      $display("FAIL after_rst_pass got %b want 1", a_pass_done);
    end
  endtask

  task automatic test_ignored_inputs;
    int ready_seen;
    ready_seen = 0;
    a_xfers = 0;
    @(posedge prog_clk); #1;
    a_valid = 1; a_data = 8'hFF;
    repeat (3) begin
      @(negedge prog_clk);
      if (a_ready) ready_seen++;
    end
    @(posedge prog_clk); #1;
    a_valid = 0;
    checks++;
    if (ready_seen != 0 || a_xfers != 0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid ready %0d words %0d busy %b want 0 0 0", ready_seen, a_xfers, a_busy);
    end
    run_a(1'b0, 3);
    check_a_stream("mid_start", 6, 8);
  endtask

  initial begin
    test_reset;
    test_load_no_verify;
    test_load_verify;
    test_stuck_flop;
    test_multi_word(0, 44, "words");
    test_multi_word(5, 54, "gap");
    test_reset_mid_load;
    test_ignored_inputs;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
